// File: rtl/vram_arbiter.sv
// Text-mode cell RAM arbiter: fixed-latency VGA cell fetch with absolute priority, host req/ack port in idle slots.
// Optional power-on clear engine enabled by defining VRAM_CLEAR_EN.
module vram_arbiter #(
    parameter int unsigned          ADDR_W      = 12,
    parameter int unsigned          DATA_W      = 16,
    parameter logic [DATA_W-1:0]    CLEAR_WORD  = DATA_W'(16'h0720),
    parameter int unsigned          CLEAR_CELLS = 2400
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              fetch_cell,
    input  logic [ADDR_W-1:0] cell_addr,
    output logic [DATA_W-1:0] cell_data,
    output logic              cell_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              clear_busy
);

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_ISSUED = 2'd1,
        H_DONE   = 2'd2
    } host_state_e;

    host_state_e       state_q, state_d;
    logic              fetch_p1_q, fetch_p1_d;
    logic [DATA_W-1:0] cell_data_q, cell_data_d;
    logic              cell_valid_q, cell_valid_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rd_q, host_rd_d;
    logic [ADDR_W-1:0] clr_addr_w;

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Clear engine advances only in slots not taken by a VGA fetch.
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (clr_busy_q && !fetch_cell) begin
            if (clr_addr_q == ADDR_W'(CLEAR_CELLS - 1)) begin
                clr_busy_d = 1'b0;
            end else begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            clr_busy_q <= 1'b1;
            clr_addr_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clear_busy = clr_busy_q;
    assign clr_addr_w = clr_addr_q;
`else
    assign clear_busy = 1'b0;
    assign clr_addr_w = '0;
`endif

    // Port grant (fetch > clear > host), fetch pipeline and host FSM.
    always_comb begin
        logic host_grant;
        host_grant   = 1'b0;
        state_d      = state_q;
        fetch_p1_d   = fetch_cell;
        cell_data_d  = cell_data_q;
        cell_valid_d = 1'b0;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        host_rd_d    = host_rd_q;
        ram_addr     = cell_addr;
        ram_we       = 1'b0;
        ram_wdata    = '0;

        if (!rst) begin
            if (fetch_cell) begin
                ram_addr = cell_addr;
            end else if (clear_busy) begin
                ram_addr  = clr_addr_w;
                ram_we    = 1'b1;
                ram_wdata = CLEAR_WORD;
            end else if (state_q == H_IDLE && host_req) begin
                host_grant = 1'b1;
                ram_addr   = host_addr;
                ram_we     = host_we;
                ram_wdata  = host_wdata;
            end
        end

        if (fetch_p1_q) begin
            cell_data_d  = ram_rdata;
            cell_valid_d = 1'b1;
        end

        case (state_q)
            H_IDLE: begin
                if (host_grant) begin
                    state_d   = H_ISSUED;
                    host_rd_d = !host_we;
                end
            end
            H_ISSUED: begin
                if (host_rd_q) begin
                    host_rdata_d = ram_rdata;
                end
                host_ack_d = 1'b1;
                state_d    = H_DONE;
            end
            H_DONE: begin
                state_d = H_IDLE;
            end
            default: begin
                state_d = H_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q      <= H_IDLE;
            fetch_p1_q   <= 1'b0;
            cell_data_q  <= '0;
            cell_valid_q <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            host_rd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_p1_q   <= fetch_p1_d;
            cell_data_q  <= cell_data_d;
            cell_valid_q <= cell_valid_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            host_rd_q    <= host_rd_d;
        end
    end

    assign cell_data  = cell_data_q;
    assign cell_valid = cell_valid_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Controller for the text-mode cell RAM that feeds the VGA character pipeline. It shares one single-port block RAM (1-cycle read latency, iCE40 EBR style) between two requesters: the VGA cell fetch (fetch_cell/cell_addr) and a host read/write port with a req/ack handshake. VGA fetches have absolute priority and fixed latency. The host uses the idle slots between character fetches.

Parameters:
ADDR_W, 12, cell address width (4096 cells)
DATA_W, 16, cell word width (char[7:0], attr[15:8])
CLEAR_WORD, 16'h0720, fill word for the power-on clear (space, grey on black)
CLEAR_CELLS, 2400, number of cells cleared from address 0 (80x30)

Ports:
clk_vga  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
fetch_cell  in  1  VGA cell fetch strobe, one cycle per request
cell_addr  in  ADDR_W  cell address, valid with fetch_cell
cell_data  out  DATA_W  fetched cell word
cell_valid  out  1  one-cycle pulse: cell_data updated
host_req  in  1  host request; held until host_ack
host_we  in  1  1=write, 0=read; held with host_req
host_addr  in  ADDR_W  host address; held with host_req
host_wdata  in  DATA_W  host write data; held with host_req
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data; valid in the host_ack cycle, then held
ram_addr  out  ADDR_W  RAM address, combinational from the current-cycle grant
ram_we  out  1  RAM write enable, combinational
ram_wdata  out  DATA_W  RAM write data, combinational
ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address
clear_busy  out  1  power-on clear in progress

Behaviour:
- Reset values: cell_data=0, cell_valid=0, host_ack=0, host_rdata=0, ram_we=0, host FSM=H_IDLE. clear_busy=1 if the optional feature is enabled, else 0.
- Port grant priority per cycle: fetch_cell > clear engine > host issue > none.
- VGA path: fetch_cell high in cycle N -> ram_addr=cell_addr, ram_we=0 in N. ram_rdata is captured at the end of N+1. cell_data/cell_valid appear in N+2. Fixed latency 2, never stalled, fully pipelined (back-to-back fetches allowed).
- Host FSM states:
  - H_IDLE: if host_req && !fetch_cell && !clear_busy -> drive ram_addr/ram_we/ram_wdata from the host inputs (grant cycle G), go to H_ISSUED. Otherwise stay.
  - H_ISSUED (G+1): capture ram_rdata into host_rdata if it is a read (write leaves host_rdata unchanged), go to H_DONE. The port is free for fetch_cell in this cycle.
  - H_DONE (G+2): host_ack=1, go to H_IDLE.
- The next host request is sampled no earlier than G+3. A host_req still high then is a new transaction.
- Write and read both ack at G+2.
- Idle port: ram_we=0, ram_addr=cell_addr, ram_wdata=0.
- Starvation: fetch_cell held high continuously blocks the host indefinitely. This is legal, with no timeout. The VGA issues at most 1 fetch per 8 clocks.
- host_req dropped before ack: undefined, not supported.
- Reset mid-transaction: in-flight host op is dropped with no ack, and any pending cell_valid is suppressed. A RAM write already issued in G remains in RAM.
- Host address range: address wrap is by width only; addresses >= CLEAR_CELLS are legal.

Optional Feature:
Macro VRAM_CLEAR_EN.
- Defined: after rst, the clear engine writes CLEAR_WORD to addresses 0..CLEAR_CELLS-1, one per cycle, in cycles where fetch_cell is low (fetch steals the slot and the counter holds).
  - clear_busy stays high until the cycle after the last write, then drops to 0.
  - The host is not granted while clear_busy is high.
  - VGA fetches during clear return whatever the RAM holds.
  - rst during clear restarts the clear from address 0.
- Not defined: no clear engine, clear_busy tied 0, host eligible from the first cycle after reset.

Test Plan:
- Read latency: rst, then fetch_cell with cell_addr=12'h005 and RAM model holding 16'h1E41 -> cell_valid pulse exactly 2 cycles later, cell_data=16'h1E41. Also fetches 3 consecutive cycles -> 3 consecutive cell_valid pulses in order.
- Host write then read: host_we=1, addr 12'h100, wdata 16'hABCD, no fetch -> ram_we high for 1 cycle, host_ack 2 cycles after grant. Then a read of 12'h100 -> host_ack with host_rdata=16'hABCD.
- Collision: fetch_cell and host_req asserted in the same cycle -> RAM sees cell_addr first and the host is granted the next cycle. cell_valid at N+2, host_ack at N+3.
- Fetch during H_ISSUED: host granted in G, fetch_cell in G+1 -> both complete, cell_valid at G+3, host_ack at G+2, no data corruption.
- Reset mid-op: rst asserted in H_ISSUED -> no host_ack, cell_valid 0, FSM in H_IDLE the next cycle. A re-issued request completes normally.
- VRAM_CLEAR_EN: rst with no fetches -> clear_busy high 2400 cycles, RAM addresses 0..2399 = 16'h0720, host_req held throughout acked only after clear_busy falls. With a fetch every 8 cycles, clear_busy lasts 2400 plus the number of stolen cycles.
